// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU: opcode and
// state encodings plus helpers that locate instruction fields from DATA_W.
package cpu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 3'd0,
        OP_ASHL   = 3'd1,
        OP_XNOR   = 3'd2,
        OP_DIV2   = 3'd3,
        OP_LOAD   = 3'd4,
        OP_STORE  = 3'd5,
        OP_COMP2S = 3'd6,
        OP_HALT   = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH0   = 3'd0,
        S_FETCH1   = 3'd1,
        S_DECODE   = 3'd2,
        S_INDIRECT = 3'd3,
        S_EXEC_MEM = 3'd4,
        S_EXEC_ALU = 3'd5,
        S_HALT     = 3'd6
    } state_e;

    // Indirect flag sits in the top bit of the instruction word.
    function automatic int unsigned ind_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

    // Opcode occupies the three bits just below the indirect flag.
    function automatic int unsigned op_msb(input int unsigned data_w);
        return data_w - 2;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned data_w);
        return data_w - 4;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the accumulator CPU.
// Ports: ac_i/dr_i operands, opcode_i selects the operation,
//        result_c_o is the new AC value, cout_c_o the carry candidate.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] ac_i,
    input  logic [DATA_W-1:0] dr_i,
    input  opcode_e           opcode_i,
    output logic [DATA_W-1:0] result_c_o,
    output logic              cout_c_o
);

    logic [DATA_W:0] sum;

    // Operation select; non-ALU opcodes pass AC through untouched.
    always_comb begin
        sum        = {1'b0, ac_i} + {1'b0, dr_i};
        result_c_o = ac_i;
        cout_c_o   = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                result_c_o = sum[DATA_W-1:0];
                cout_c_o   = sum[DATA_W];
            end
            OP_ASHL: begin
                result_c_o = {dr_i[DATA_W-2:0], 1'b0};
                cout_c_o   = dr_i[DATA_W-1];
            end
            OP_XNOR:   result_c_o = ~(ac_i ^ dr_i);
            OP_DIV2:   result_c_o = {dr_i[DATA_W-1], dr_i[DATA_W-1:1]};
            OP_LOAD:   result_c_o = dr_i;
            OP_COMP2S: result_c_o = (~dr_i) + DATA_W'(1);
            default: begin
                result_c_o = ac_i;
                cout_c_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised multi-cycle accumulator CPU driving a single-port memory
// with a ready handshake. DATA_W must be at least ADDR_W+4.
// Ports: clk/clr (sync active-high reset), mem_read/mem_write strobes,
//        mem_addr (=AR), mem_wdata (=AC), mem_rdata/mem_ready from memory,
//        halted, acc_out (=AC), carry.
module acc_cpu_param
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [DATA_W-1:0] acc_out,
    output logic              carry
);

    localparam int unsigned IND_BIT = ind_bit(DATA_W);
    localparam int unsigned OP_MSB  = op_msb(DATA_W);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              carry_q, carry_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              halted_q, halted_d;

    opcode_e           ir_op;
    opcode_e           ir_op_next;
    logic [DATA_W-1:0] alu_result_c;
    logic              alu_cout_c;

    assign ir_op      = opcode_e'(ir_q[OP_MSB -: OP_W]);
    assign ir_op_next = opcode_e'(ir_d[OP_MSB -: OP_W]);

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .ac_i       (ac_q),
        .dr_i       (dr_q),
        .opcode_i   (ir_op),
        .result_c_o (alu_result_c),
        .cout_c_o   (alu_cout_c)
    );

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ar_d        = ar_q;
        dr_d        = dr_q;
        ac_d        = ac_q;
        ir_d        = ir_q;
        carry_d     = carry_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        halted_d    = 1'b0;

        case (state_q)
            S_FETCH0: begin
                ar_d    = pc_q;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ar_d = ir_q[ADDR_W-1:0];
                if (ir_op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (ir_q[IND_BIT]) begin
                    state_d = S_INDIRECT;
                end else begin
                    state_d = S_EXEC_MEM;
                end
            end
            S_INDIRECT: begin
                if (mem_ready) begin
                    ar_d    = mem_rdata[ADDR_W-1:0];
                    state_d = S_EXEC_MEM;
                end
            end
            S_EXEC_MEM: begin
                if (mem_ready) begin
                    if (ir_op == OP_STORE) begin
                        state_d = S_FETCH0;
                    end else begin
                        dr_d    = mem_rdata;
                        state_d = S_EXEC_ALU;
                    end
                end
            end
            S_EXEC_ALU: begin
                ac_d = alu_result_c;
                if ((ir_op == OP_ADD) || (ir_op == OP_ASHL)) begin
                    carry_d = alu_cout_c;
                end
                state_d = S_FETCH0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH0;
            end
        endcase

        // Strobes follow the state being entered so they register cleanly
        // and hold steady while a stalled state repeats.
        mem_read_d  = (state_d == S_FETCH1) || (state_d == S_INDIRECT) ||
                      ((state_d == S_EXEC_MEM) && (ir_op_next != OP_STORE));
        mem_write_d = (state_d == S_EXEC_MEM) && (ir_op_next == OP_STORE);
        halted_d    = (state_d == S_HALT);
    end

    // State and register update; clr wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_FETCH0;
            pc_q        <= '0;
            ar_q        <= '0;
            dr_q        <= '0;
            ac_q        <= '0;
            ir_q        <= '0;
            carry_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ar_q        <= ar_d;
            dr_q        <= dr_d;
            ac_q        <= ac_d;
            ir_q        <= ir_d;
            carry_q     <= carry_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = ar_q;
    assign mem_wdata = ac_q;
    assign halted    = halted_q;
    assign acc_out   = ac_q;
    assign carry     = carry_q;

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
Parametrised multi-cycle accumulator CPU and the next generation of the team's 8-bit/4-bit-address core. Data and address widths are set by parameters. A mem_ready handshake lets the core stall on slow memory. It adds a HALT state, a carry flag and PC wrap-around. It sits between the test-bench memory model and the top level, and drives a single-port memory.

Parameters:
DATA_W, 8, width of AC, DR, IR, memory word; must satisfy DATA_W >= ADDR_W+4
ADDR_W, 4, width of PC, AR, memory address

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, synchronous, active-high
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address (= AR)
mem_wdata  output  DATA_W  write data (= AC)
mem_rdata  input  DATA_W  read data, valid when mem_ready=1
mem_ready  input  1  memory completes the current read/write this cycle
halted  output  1  core is in HALT
acc_out  output  DATA_W  AC value
carry  output  1  carry flag

Behaviour:
- Instruction format: bit DATA_W-1 = I (indirect); bits DATA_W-2..DATA_W-4 = opcode; bits ADDR_W-1..0 = address; remaining bits ignored.
- Opcodes: 0 ADD AC<=AC+DR, carry<=carry-out; 1 ASHL AC<=DR<<1, carry<=DR[MSB]; 2 XNOR AC<=~(AC^DR); 3 DIV2 AC<=DR>>>1 (arithmetic); 4 LOAD AC<=DR; 5 STORE M[AR]<=AC; 6 COMP2S AC<=-DR (mod 2^DATA_W); 7 HALT.
- carry changes only on ADD and ASHL.
- States, in order:
  - FETCH0: AR<=PC.
  - FETCH1: mem_read=1; on mem_ready, IR<=rdata and PC<=PC+1.
  - DECODE: AR<=IR address field; HALT opcode goes to HALT; I=1 goes to INDIRECT; otherwise EXEC_MEM.
  - INDIRECT: mem_read=1; on mem_ready, AR<=rdata[ADDR_W-1:0], then EXEC_MEM.
  - EXEC_MEM: STORE drives mem_write=1 and, on mem_ready, goes to FETCH0. All other opcodes drive mem_read=1 and, on mem_ready, load DR<=rdata and go to EXEC_ALU.
  - EXEC_ALU: AC and carry updated, then FETCH0.
  - HALT: absorbing; halted=1; only clr exits.
- Handshake:
  - mem_read/mem_write are decoded from state only and are never both high.
  - The strobe, mem_addr and mem_wdata stay stable while mem_ready=0; the state holds.
  - mem_ready is ignored in states with no strobe.
- Latency with mem_ready tied high:
  - ALU/LOAD ops: 5 cycles direct, 6 indirect.
  - STORE: 4 cycles direct, 5 indirect.
  - HALT: 3 cycles to enter HALT.
  - Each stalled cycle adds 1.
- PC increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- Reset: clr=1 at a rising edge sets PC, AR, DR, AC, IR and carry to 0 and state to FETCH0. clr overrides every other update, including a mem_ready in the same cycle.
- Outputs after reset: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, halted=0, acc_out=0, carry=0.
- clr mid-operation (including during a stalled write) aborts the instruction: the strobe drops the cycle after the reset edge and no register commits.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode enum (OP_ADD..OP_HALT);
  - state enum (S_FETCH0, S_FETCH1, S_DECODE, S_INDIRECT, S_EXEC_MEM, S_EXEC_ALU, S_HALT);
  - localparam functions for the I/opcode field positions from DATA_W.
- One sub-module, cpu_alu: combinational, parametrised on DATA_W. Inputs ac, dr, opcode; outputs result and cout.
- The FSM and registers live in acc_cpu_param.

Test Plan:
- Program run, DATA_W=8, ADDR_W=4, ready=1:
  - Stimulus: mem[0..3]=0x4A,0x0B,0x5C,0x70; mem[A]=0x05; mem[B]=0x03.
  - Response: mem[C]=0x08, acc_out=0x08, carry=0, halted rises after exactly 17 edges post-reset and stays high.
- Carry:
  - Stimulus: LOAD of 0xF0, then ADD of 0x20.
  - Response: acc_out=0x10, carry=1.
  - Stimulus: ASHL of 0x81.
  - Response: acc_out=0x02, carry=1.
  - Stimulus: DIV2 of 0x81.
  - Response: acc_out=0xC0.
  - Stimulus: COMP2S of 0x05.
  - Response: acc_out=0xFB.
- Indirect:
  - Stimulus: mem[0]=0xC9, mem[9]=0x0E, mem[E]=0x7F.
  - Response: acc_out=0x7F after 6 cycles; mem_addr sequence 0,0,9,E.
- Stall:
  - Stimulus: mem_ready low for 3 cycles during FETCH1 and 2 cycles during a STORE.
  - Response: mem_read/mem_write and mem_addr stay stable throughout, exactly one write occurs, and the program takes 5 extra cycles.
- Wrap:
  - Stimulus: mem[0..15] all 0x2F (XNOR of mem[F]).
  - Response: after the instruction at address 15, the next FETCH1 shows mem_addr=0.
- Reset mid-write:
  - Stimulus: assert clr while STORE is stalled with ready=0.
  - Response: mem_write=0 the next cycle, memory unchanged, PC=AC=carry=0, fetch restarts at address 0.
